// File: rtl/junction_phase_scheduler.sv
// Three-way junction phase scheduler: highway plus round-robin side slot (country, farm, pedestrian).
// Optional pedestrian crossing enabled by defining PED_CROSSING_EN.
module junction_phase_scheduler #(
  parameter int Y2RDELAY      = 3,
  parameter int R2GDELAY      = 2,
  parameter int HWY_MIN_GREEN = 8,
  parameter int SIDE_GREEN    = 6
) (
  input  logic       CLK,
  input  logic       CLEAR,
  input  logic       CAR_ON_CNTRY_RD,
  input  logic       CAR_ON_FARM_RD,
  input  logic       PED_REQ,
  output logic [1:0] HWY_SIG,
  output logic [1:0] CNTRY_SIG,
  output logic [1:0] FARM_SIG,
  output logic       WALK,
  output logic       PED_PENDING,
  output logic [2:0] dbg_state
);

`ifdef PED_CROSSING_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  localparam int MAX_A = (Y2RDELAY > R2GDELAY) ? Y2RDELAY : R2GDELAY;
  localparam int MAX_B = (HWY_MIN_GREEN > SIDE_GREEN) ? HWY_MIN_GREEN : SIDE_GREEN;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW    = $clog2(MAX_P + 1);

  localparam logic [1:0] LAMP_RED    = 2'd0;
  localparam logic [1:0] LAMP_YELLOW = 2'd1;
  localparam logic [1:0] LAMP_GREEN  = 2'd2;

  typedef enum logic [2:0] {
    HWY_GRN  = 3'd0,
    HWY_YLW  = 3'd1,
    RED_IN   = 3'd2,
    SIDE_GRN = 3'd3,
    SIDE_YLW = 3'd4,
    RED_OUT  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    G_CNTRY = 2'd0,
    G_FARM  = 2'd1,
    G_PED   = 2'd2
  } grant_t;

  state_t          state, state_n;
  grant_t          grant, grant_n, pick;
  logic [TW-1:0]   timer;
  logic            ped, ped_clr;
  logic            rc, rf, rp, any_req;

  assign rc      = CAR_ON_CNTRY_RD;
  assign rf      = CAR_ON_FARM_RD;
  assign rp      = ped;
  assign any_req = rc | rf | rp;

  // Search starts at the requester after the last grant.
  always_comb begin
    pick = grant;
    case (grant)
      G_CNTRY: pick = rf ? G_FARM  : (rp ? G_PED   : G_CNTRY);
      G_FARM:  pick = rp ? G_PED   : (rc ? G_CNTRY : G_FARM);
      default: pick = rc ? G_CNTRY : (rf ? G_FARM  : G_PED);
    endcase
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    ped_clr = 1'b0;
    case (state)
      HWY_GRN: if (timer >= TW'(HWY_MIN_GREEN - 1) && any_req) begin
        state_n = HWY_YLW;
        grant_n = pick;
      end
      HWY_YLW:  if (timer == TW'(Y2RDELAY - 1)) state_n = RED_IN;
      RED_IN: if (timer == TW'(R2GDELAY - 1)) begin
        state_n = SIDE_GRN;
        ped_clr = (grant == G_PED);
      end
      SIDE_GRN: if (timer == TW'(SIDE_GREEN - 1)) state_n = SIDE_YLW;
      SIDE_YLW: if (timer == TW'(Y2RDELAY - 1)) state_n = RED_OUT;
      RED_OUT:  if (timer == TW'(R2GDELAY - 1)) state_n = HWY_GRN;
      default:  state_n = HWY_GRN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLEAR) begin
      state <= HWY_GRN;
      grant <= G_PED;
      timer <= '0;
      ped   <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      if (state_n != state) timer <= '0;
      else if (timer != {TW{1'b1}}) timer <= timer + 1'b1;
      // A press on the grant edge wins over the clear and is served next round.
      if (PED_EN && PED_REQ) ped <= 1'b1;
      else if (ped_clr)      ped <= 1'b0;
    end
  end

  always_comb begin
    HWY_SIG   = LAMP_RED;
    CNTRY_SIG = LAMP_RED;
    FARM_SIG  = LAMP_RED;
    WALK      = 1'b0;
    case (state)
      HWY_GRN: HWY_SIG = LAMP_GREEN;
      HWY_YLW: HWY_SIG = LAMP_YELLOW;
      SIDE_GRN: case (grant)
        G_CNTRY: CNTRY_SIG = LAMP_GREEN;
        G_FARM:  FARM_SIG  = LAMP_GREEN;
        default: WALK      = PED_EN;
      endcase
      SIDE_YLW: case (grant)
        G_CNTRY: CNTRY_SIG = LAMP_YELLOW;
        G_FARM:  FARM_SIG  = LAMP_YELLOW;
        default: WALK      = 1'b0;
      endcase
      default: ;
    endcase
  end

  assign PED_PENDING = ped;
  assign dbg_state   = state;

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// Bench for junction_phase_scheduler: phase/countdown reference model with an expected-output queue.
// Follows the DUT build: pedestrian behaviour is modelled only when PED_CROSSING_EN is defined.
module tb_junction_phase_scheduler;

`ifdef PED_CROSSING_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  localparam int Y2R = 3, R2G = 2, MING = 8, SIDEG = 6;

  logic       CLK, CLEAR, CAR_ON_CNTRY_RD, CAR_ON_FARM_RD, PED_REQ;
  logic [1:0] HWY_SIG, CNTRY_SIG, FARM_SIG;
  logic       WALK, PED_PENDING;
  logic [2:0] dbg_state;

  junction_phase_scheduler #(
    .Y2RDELAY(Y2R), .R2GDELAY(R2G), .HWY_MIN_GREEN(MING), .SIDE_GREEN(SIDEG)
  ) dut (
    .CLK(CLK), .CLEAR(CLEAR), .CAR_ON_CNTRY_RD(CAR_ON_CNTRY_RD),
    .CAR_ON_FARM_RD(CAR_ON_FARM_RD), .PED_REQ(PED_REQ),
    .HWY_SIG(HWY_SIG), .CNTRY_SIG(CNTRY_SIG), .FARM_SIG(FARM_SIG),
    .WALK(WALK), .PED_PENDING(PED_PENDING), .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // scoreboard
  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // reference model: phase index 0..5 with an age count, grants 0=country 1=farm 2=ped
  int m_phase, m_age, m_grant;
  bit m_ped;
  int dur[6];

  function automatic void model_step(bit clr, bit rc, bit rf, bit pr);
    bit req[3];
    bit found;
    int idx;
    if (clr) begin
      m_phase = 0; m_age = 0; m_grant = 2; m_ped = 0;
      return;
    end
    req[0] = rc; req[1] = rf; req[2] = m_ped;
    if (m_phase == 0) begin
      if (m_age + 1 >= MING && (rc || rf || m_ped)) begin
        found = 0;
        for (int k = 1; k <= 3; k++) begin
          idx = (m_grant + k) % 3;
          if (!found && req[idx]) begin
            m_grant = idx;
            found = 1;
          end
        end
        m_phase = 1; m_age = 0;
      end else begin
        m_age++;
      end
    end else if (m_age + 1 == dur[m_phase]) begin
      m_phase = (m_phase + 1) % 6;
      m_age = 0;
      if (m_phase == 3 && m_grant == 2) m_ped = 0;
    end else begin
      m_age++;
    end
    if (PED_EN && pr) m_ped = 1;
  endfunction

  function automatic logic [7:0] model_out();
    logic [1:0] h, c, f;
    logic w;
    h = 2'd0; c = 2'd0; f = 2'd0; w = 1'b0;
    case (m_phase)
      0: h = 2'd2;
      1: h = 2'd1;
      3: begin
        if (m_grant == 0) c = 2'd2;
        else if (m_grant == 1) f = 2'd2;
        else w = 1'b1;
      end
      4: begin
        if (m_grant == 0) c = 2'd1;
        else if (m_grant == 1) f = 2'd1;
      end
      default: ;
    endcase
    return {h, c, f, w, m_ped};
  endfunction

  // driver: apply inputs, clock once, advance model, sample 1ns after the edge
  task automatic tick(input bit clr, input bit rc, input bit rf, input bit pr);
    CLEAR = clr; CAR_ON_CNTRY_RD = rc; CAR_ON_FARM_RD = rf; PED_REQ = pr;
    @(posedge CLK);
    model_step(clr, rc, rf, pr);
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0);
    exp_q.delete();
  endtask

  function automatic logic [7:0] actual();
    return {HWY_SIG, CNTRY_SIG, FARM_SIG, WALK, PED_PENDING};
  endfunction

  task automatic test_reset();
    logic [7:0] e;
    for (int i = 0; i < 5; i++) begin
      tick(1, $urandom_range(0, 1), $urandom_range(0, 1), 1);
      e = exp_q.pop_front();
      total++;
      if (actual() !== e) begin
        bad++;
        $display("FAIL reset_model cyc=%0d got=%b want=%b", i, actual(), e);
      end
      total++;
      if (HWY_SIG !== 2'd2 || CNTRY_SIG !== 2'd0 || FARM_SIG !== 2'd0 || WALK !== 1'b0 || PED_PENDING !== 1'b0) begin
        bad++;
        $display("FAIL reset_values cyc=%0d got=%b want=10000000", i, actual());
      end
    end
  endtask

  task automatic test_idle();
    logic [7:0] e;
    do_reset(5);
    for (int i = 0; i < 100; i++) begin
      tick(0, 0, 0, 0);
      e = exp_q.pop_front();
      total++;
      if (actual() !== e || actual() !== 8'b10_00_00_0_0) begin
        bad++;
        $display("FAIL idle cyc=%0d got=%b want=%b", i, actual(), e);
      end
    end
  endtask

  task automatic test_country();
    logic [7:0] e;
    logic [1:0] eh, ec;
    int c;
    do_reset(5);
    for (int i = 0; i < 26; i++) begin
      tick(0, 1, 0, 0);
      c = i + 1;
      e = exp_q.pop_front();
      total++;
      if (actual() !== e) begin
        bad++;
        $display("FAIL country_model cyc=%0d got=%b want=%b", c, actual(), e);
      end
      eh = 2'd0; ec = 2'd0;
      if (c < 8 || c >= 24) eh = 2'd2;
      else if (c <= 10) eh = 2'd1;
      else if (c >= 13 && c <= 18) ec = 2'd2;
      else if (c >= 19 && c <= 21) ec = 2'd1;
      total++;
      if (HWY_SIG !== eh || CNTRY_SIG !== ec || FARM_SIG !== 2'd0) begin
        bad++;
        $display("FAIL country_timeline cyc=%0d hwy=%0d cntry=%0d farm=%0d want hwy=%0d cntry=%0d farm=0",
                 c, HWY_SIG, CNTRY_SIG, FARM_SIG, eh, ec);
      end
    end
  endtask

  task automatic test_all_held();
    logic [7:0] e;
    int grants[4];
    int want[4];
    int n_grants, hwy_run, g;
    bit prev_side, side;
    want = PED_EN ? '{0, 1, 2, 0} : '{0, 1, 0, 1};
    do_reset(5);
    n_grants = 0; prev_side = 0;
    hwy_run = (HWY_SIG == 2'd2) ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      tick(0, 1, 1, 1);
      e = exp_q.pop_front();
      total++;
      if (actual() !== e) begin
        bad++;
        $display("FAIL all_held_model cyc=%0d got=%b want=%b", i + 1, actual(), e);
      end
      if (HWY_SIG == 2'd1 && hwy_run > 0) begin
        total++;
        if (hwy_run < MING) begin
          bad++;
          $display("FAIL min_green cyc=%0d green_run=%0d want>=%0d", i + 1, hwy_run, MING);
        end
      end
      hwy_run = (HWY_SIG == 2'd2) ? hwy_run + 1 : 0;
      side = (CNTRY_SIG == 2'd2) || (FARM_SIG == 2'd2) || WALK;
      if (side && !prev_side && n_grants < 4) begin
        g = (CNTRY_SIG == 2'd2) ? 0 : (FARM_SIG == 2'd2) ? 1 : 2;
        grants[n_grants] = g;
        n_grants++;
      end
      prev_side = side;
    end
    total++;
    if (n_grants != 4) begin
      bad++;
      $display("FAIL grant_count got=%0d want=4", n_grants);
    end
    for (int k = 0; k < n_grants; k++) begin
      total++;
      if (grants[k] != want[k]) begin
        bad++;
        $display("FAIL grant_order idx=%0d got=%0d want=%0d", k, grants[k], want[k]);
      end
    end
  endtask

  task automatic test_ped_pulse();
    logic [7:0] e;
    int walk_cycles;
    walk_cycles = 0;
    do_reset(5);
    for (int i = 0; i < 50; i++) begin
      tick(0, 0, 1, (i == 9));
      e = exp_q.pop_front();
      total++;
      if (actual() !== e) begin
        bad++;
        $display("FAIL ped_pulse_model cyc=%0d got=%b want=%b", i + 1, actual(), e);
      end
      if (i + 1 == 10) begin
        total++;
        if (PED_PENDING !== PED_EN || HWY_SIG !== 2'd1) begin
          bad++;
          $display("FAIL ped_latch cyc=10 pending=%b hwy=%0d want pending=%b hwy=1", PED_PENDING, HWY_SIG, PED_EN);
        end
      end
      if (i + 1 == 37) begin
        total++;
        if (PED_PENDING !== 1'b0 || WALK !== PED_EN) begin
          bad++;
          $display("FAIL walk_entry cyc=37 pending=%b walk=%b want pending=0 walk=%b", PED_PENDING, WALK, PED_EN);
        end
      end
      if (WALK) walk_cycles++;
    end
    total++;
    if (walk_cycles != (PED_EN ? SIDEG : 0)) begin
      bad++;
      $display("FAIL walk_len got=%0d want=%0d", walk_cycles, PED_EN ? SIDEG : 0);
    end
  endtask

  task automatic test_clear_mid();
    logic [7:0] e;
    bit seen;
    do_reset(5);
    for (int i = 0; i < 15; i++) begin
      tick(0, 1, 0, 0);
      e = exp_q.pop_front();
      total++;
      if (actual() !== e) begin
        bad++;
        $display("FAIL clear_mid_pre cyc=%0d got=%b want=%b", i + 1, actual(), e);
      end
    end
    total++;
    if (CNTRY_SIG !== 2'd2) begin
      bad++;
      $display("FAIL clear_mid_setup cntry=%0d want=2", CNTRY_SIG);
    end
    tick(1, 1, 0, 1);
    e = exp_q.pop_front();
    total++;
    if (actual() !== e || actual() !== 8'b10_00_00_0_0) begin
      bad++;
      $display("FAIL clear_mid_reset got=%b want=%b", actual(), e);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick(0, 1, 1, 0);
      e = exp_q.pop_front();
      total++;
      if (actual() !== e) begin
        bad++;
        $display("FAIL clear_mid_post cyc=%0d got=%b want=%b", i, actual(), e);
      end
      if (!seen && (CNTRY_SIG == 2'd2 || FARM_SIG == 2'd2)) begin
        seen = 1;
        total++;
        if (CNTRY_SIG !== 2'd2) begin
          bad++;
          $display("FAIL clear_mid_first_grant cntry=%0d farm=%0d want cntry=2", CNTRY_SIG, FARM_SIG);
        end
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL clear_mid_timeout got=no_grant want=grant_within_40");
    end
  endtask

  task automatic test_ped_held_no_cars();
    logic [7:0] e;
    do_reset(5);
    for (int i = 0; i < 50; i++) begin
      tick(0, 0, 0, 1);
      e = exp_q.pop_front();
      total++;
      if (actual() !== e) begin
        bad++;
        $display("FAIL ped_held cyc=%0d got=%b want=%b", i + 1, actual(), e);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] e;
    bit rc, rf;
    rc = 0; rf = 0;
    do_reset(5);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) rc = ~rc;
      if ($urandom_range(0, 7) == 0) rf = ~rf;
      tick($urandom_range(0, 149) == 0, rc, rf, $urandom_range(0, 24) == 0);
      e = exp_q.pop_front();
      total++;
      if (actual() !== e) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b want=%b", i, actual(), e);
      end
    end
  endtask

  initial begin
    dur[0] = 0; dur[1] = Y2R; dur[2] = R2G; dur[3] = SIDEG; dur[4] = Y2R; dur[5] = R2G;
    m_phase = 0; m_age = 0; m_grant = 2; m_ped = 0;
    CLEAR = 1; CAR_ON_CNTRY_RD = 0; CAR_ON_FARM_RD = 0; PED_REQ = 0;
    test_reset();
    test_idle();
    test_country();
    test_all_held();
    test_ped_pulse();
    test_clear_mid();
    test_ped_held_no_cars();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/junction_phase_scheduler.md
# junction_phase_scheduler

Phase scheduler for a three-way junction: one highway and two side roads (country, farm), plus an optional pedestrian crossing. It extends the highway/country controller with a shared side-phase slot. Requesters (country car, farm car, pedestrian) are granted round-robin, one at a time, and each grant runs a fixed green/yellow/all-red sequence. It sits directly above the lamp drivers and is driven by the road sensors and the crossing push-button.

## Interface
- `Y2RDELAY`, 3: yellow duration in cycles; must be ≥1.
- `R2GDELAY`, 2: all-red clearance duration in cycles; must be ≥1.
- `HWY_MIN_GREEN`, 8: minimum highway green in cycles; must be ≥1.
- `SIDE_GREEN`, 6: side-road green or WALK duration in cycles; must be ≥1.
- `CLK` in 1: single clock; all state changes on its rising edge.
- `CLEAR` in 1: synchronous, active-high reset.
- `CAR_ON_CNTRY_RD` in 1: country road sensor (level).
- `CAR_ON_FARM_RD` in 1: farm road sensor (level).
- `PED_REQ` in 1: crossing button. Any pulse of one or more cycles is latched.
- `HWY_SIG` out 2: highway lamp.
- `CNTRY_SIG` out 2: country lamp.
- `FARM_SIG` out 2: farm lamp.
- `WALK` out 1: pedestrian walk lamp.
- `PED_PENDING` out 1: pedestrian latch, visible externally.
- Lamp encoding: RED=2'd0, YELLOW=2'd1, GREEN=2'd2. Value 2'd3 is never driven.

## Operation
- States:
  - `HWY_GRN`
  - `HWY_YLW`
  - `RED_IN`
  - `SIDE_GRN`
  - `SIDE_YLW`
  - `RED_OUT`
- Grant register `G` ∈ {CNTRY, FARM, PED}. `G` is loaded only on the `HWY_GRN`→`HWY_YLW` transition.
- Requests:
  - rc = `CAR_ON_CNTRY_RD`
  - rf = `CAR_ON_FARM_RD`
  - rp = ped latch
- Round-robin: search order starts at the requester after the last granted one, cycling CNTRY→FARM→PED→CNTRY. The first requester with a request set wins.
- `HWY_GRN` → `HWY_YLW`: taken when timer ≥ `HWY_MIN_GREEN`−1 and any request is set. With no request, the state holds indefinitely and the timer saturates.
- Fixed-duration states, each followed by the next state in the sequence:
  - `HWY_YLW`: exactly `Y2RDELAY` cycles.
  - `RED_IN`: exactly `R2GDELAY` cycles.
  - `SIDE_GRN`: exactly `SIDE_GREEN` cycles.
  - `SIDE_YLW`: exactly `Y2RDELAY` cycles.
  - `RED_OUT`: exactly `R2GDELAY` cycles, then → `HWY_GRN`.
- A side grant runs to completion even if its sensor drops mid-phase.
- Outputs per state (all lamps not listed are RED):
  - `HWY_GRN`: `HWY_SIG`=GREEN.
  - `HWY_YLW`: `HWY_SIG`=YELLOW.
  - `RED_IN`, `RED_OUT`: all RED, `WALK`=0.
  - `SIDE_GRN`: the lamp for `G` = GREEN. If `G`=PED, all lamps RED and `WALK`=1.
  - `SIDE_YLW`: the lamp for `G` = YELLOW. If `G`=PED, all lamps RED and `WALK`=0.
- Ped latch:
  - Set when `PED_REQ`=1.
  - Cleared on the edge entering `SIDE_GRN` with `G`=PED.
  - Set and clear in the same cycle: set wins, so a press during the grant edge is served next round.
- Timer: one counter, cleared to 0 on every state change, otherwise incremented. It is wide enough for the largest parameter.

## Timing
- Reset values (applied on the first rising edge with `CLEAR`=1, held while `CLEAR`=1):
  - state = `HWY_GRN`
  - `HWY_SIG`=GREEN, `CNTRY_SIG`=RED, `FARM_SIG`=RED
  - `WALK`=0, `PED_PENDING`=0
  - timer=0
  - round-robin pointer set so the first grant search starts at CNTRY
- `CLEAR` overrides everything, including a `PED_REQ` in the same cycle. Reset mid-phase returns to `HWY_GRN` at the next edge; no yellow is emitted.
- Outputs are decoded from the state and `G` registers only (Moore). They change on the same edge as the state transition.
- Requests are sampled at the `HWY_GRN` exit edge. The earliest exit edge is the `HWY_MIN_GREEN`-th edge after entering `HWY_GRN`.
- A request raised during any non-`HWY_GRN` state is served after the current cycle returns to `HWY_GRN` and min-green has elapsed again.
- Full side cycle: `Y2RDELAY` + `R2GDELAY` + `SIDE_GREEN` + `Y2RDELAY` + `R2GDELAY` = 16 cycles at defaults.

## Configuration
- `PED_CROSSING_EN` defined:
  - Pedestrian latch, PED grant and `WALK` present as described.
  - Round-robin runs over three requesters.
- `PED_CROSSING_EN` undefined:
  - `PED_REQ` is ignored.
  - `WALK`=0 and `PED_PENDING`=0 constantly.
  - Round-robin runs over CNTRY/FARM only.
  - Ports are unchanged.

## Test plan
All scenarios use defaults, with `CLEAR` held for 5 cycles.
- No requests for 100 cycles → `HWY_SIG`=GREEN throughout; `CNTRY_SIG`, `FARM_SIG`=RED; `WALK`=0.
- `CAR_ON_CNTRY_RD`=1 from cycle 0 after reset:
  - `HWY_SIG` goes YELLOW at cycle 8.
  - All RED at cycles 11–12.
  - `CNTRY_SIG`=GREEN at cycles 13–18, YELLOW at cycles 19–21.
  - All RED at cycles 22–23.
  - `HWY_SIG`=GREEN at cycle 24.
- rc, rf and `PED_REQ` all asserted and held → grants in order CNTRY, FARM, PED, CNTRY. Each side phase is preceded by at least 8 highway-green cycles.
- 1-cycle `PED_REQ` pulse while in `HWY_YLW` serving FARM → `PED_PENDING`=1 immediately. The pedestrian is served in the next side phase with `WALK`=1 for 6 cycles. `PED_PENDING` drops on WALK entry.
- `CLEAR` pulsed for 1 cycle during `SIDE_GRN` of CNTRY → next edge: `HWY_SIG`=GREEN, `CNTRY_SIG`=RED, `PED_PENDING`=0, timer restarts. The next grant search starts at CNTRY.
- Build without `PED_CROSSING_EN`; hold `PED_REQ`=1 for 50 cycles with no cars → `HWY_SIG` stays GREEN; `WALK`=0; `PED_PENDING`=0.
